// File: rtl/axi_ad7124_up_axi.sv
// AXI4-Lite slave bridging to the single-outstanding UP register bus.
// Reads and writes are serviced one at a time, with ack timeout and strobe checking.
module axi_ad7124_up_axi #(
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                      up_clk,
  input  logic                      up_rst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]                s_axi_awprot,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic [1:0]                s_axi_bresp,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]                s_axi_arprot,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      up_wreq,
  output logic [13:0]               up_waddr,
  output logic [31:0]               up_wdata,
  input  logic                      up_wack,
  output logic                      up_rreq,
  output logic [13:0]               up_raddr,
  input  logic [31:0]               up_rdata,
  input  logic                      up_rack
);

  typedef enum logic [2:0] {IDLE, WREQ, WWAIT, WRESP, RREQ, RWAIT, RRESP} state_t;

  state_t      state;
  logic        aw_held, w_held, ar_held;
  logic [13:0] awaddr_q, araddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [7:0]  cnt;
  logic        last_wr;

  logic        aw_hs, w_hs, ar_hs;
  logic        wr_elig, rd_elig, contested, grant_wr, grant_rd;
  logic [13:0] awaddr_n, araddr_n;
  logic [31:0] wdata_n;
  logic [3:0]  wstrb_n;
  logic        timeout;
  logic        unused_bits;

  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = !up_rst && (state == IDLE) && !aw_held;
  assign s_axi_wready  = !up_rst && (state == IDLE) && !w_held;
  assign s_axi_arready = !up_rst && (state == IDLE) && !ar_held;

  // Eligibility includes a handshake in progress so a fresh request is granted
  // on the same edge that captures it, giving the N+1 request latency.
  always_comb begin
    aw_hs     = s_axi_awvalid && s_axi_awready;
    w_hs      = s_axi_wvalid && s_axi_wready;
    ar_hs     = s_axi_arvalid && s_axi_arready;
    awaddr_n  = aw_hs ? s_axi_awaddr[15:2] : awaddr_q;
    araddr_n  = ar_hs ? s_axi_araddr[15:2] : araddr_q;
    wdata_n   = w_hs ? s_axi_wdata : wdata_q;
    wstrb_n   = w_hs ? s_axi_wstrb : wstrb_q;
    wr_elig   = (state == IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    rd_elig   = (state == IDLE) && (ar_held || ar_hs);
    contested = wr_elig && rd_elig;
    grant_wr  = contested ? !last_wr : wr_elig;
    grant_rd  = contested ? last_wr : rd_elig;
    timeout   = (cnt == 8'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      state        <= IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      ar_held      <= 1'b0;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      cnt          <= '0;
      last_wr      <= 1'b1;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= '0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= '0;
      up_wreq      <= 1'b0;
      up_waddr     <= '0;
      up_wdata     <= '0;
      up_rreq      <= 1'b0;
      up_raddr     <= '0;
    end else begin
      up_wreq <= 1'b0;
      up_rreq <= 1'b0;
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= awaddr_n;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= wdata_n;
        wstrb_q <= wstrb_n;
      end
      if (ar_hs) begin
        ar_held  <= 1'b1;
        araddr_q <= araddr_n;
      end
      case (state)
        IDLE: begin
          // Only contested grants move the fairness pointer.
          if (contested) last_wr <= grant_wr;
          if (grant_wr) begin
            if (wstrb_n != 4'hF) begin
              s_axi_bresp  <= 2'b10;
              s_axi_bvalid <= 1'b1;
              state        <= WRESP;
            end else begin
              up_wreq  <= 1'b1;
              up_waddr <= awaddr_n;
              up_wdata <= wdata_n;
              state    <= WREQ;
            end
          end else if (grant_rd) begin
            up_rreq  <= 1'b1;
            up_raddr <= araddr_n;
            state    <= RREQ;
          end
        end
        WREQ: begin
          cnt   <= '0;
          state <= WWAIT;
        end
        WWAIT: begin
          if (up_wack || timeout) begin
            s_axi_bresp  <= up_wack ? 2'b00 : 2'b10;
            s_axi_bvalid <= 1'b1;
            state        <= WRESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WRESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            state        <= IDLE;
          end
        end
        RREQ: begin
          cnt   <= '0;
          state <= RWAIT;
        end
        RWAIT: begin
          if (up_rack || timeout) begin
            s_axi_rdata  <= up_rack ? up_rdata : 32'hDEAD_DEAD;
            s_axi_rresp  <= up_rack ? 2'b00 : 2'b10;
            s_axi_rvalid <= 1'b1;
            state        <= RRESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RRESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            ar_held      <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ad7124_up_axi.sv
// Directed and randomized bench for axi_ad7124_up_axi with a transaction-level
// expectation model (latency, response code and data derived from ack delay).
module tb_axi_ad7124_up_axi;

  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        up_rst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [15:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [15:0] s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        up_wreq, up_wack, up_rreq, up_rack;
  logic [13:0] up_waddr, up_raddr;
  logic [31:0] up_wdata, up_rdata;

  int checks = 0;
  int failures = 0;
  int excl_viol = 0;
  logic any_out;

  axi_ad7124_up_axi #(.AXI_ADDR_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
    .up_clk(clk), .up_rst(up_rst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
  );

  always #5 clk = ~clk;

  assign any_out = |{s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_bresp,
                     s_axi_rvalid, s_axi_rdata, s_axi_rresp, up_wreq, up_waddr, up_wdata,
                     up_rreq, up_raddr};

  always @(negedge clk)
    if ((s_axi_bvalid && s_axi_rvalid) || (up_wreq && up_rreq)) excl_viol++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ack arrives d cycles after the request cycle; accepted while d <= TO.
  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int d, input int lead, input int hold);
    int t, nreq, lat;
    bit ok, resp_ok, stable, steady;
    logic [1:0] br;
    ok      = (strb == 4'hF);
    resp_ok = ok && (d <= TO);
    lat     = ok ? (((d <= TO) ? d : TO) + 1) : 0;
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    stable = 1'b1;
    if (lead > 0) begin
      s_axi_wvalid = 1'b1;
      chk("w_ready", 32'(s_axi_wready), 32'd1);
      step();
      s_axi_wvalid = 1'b0;
      for (int i = 1; i < lead; i++) begin
        if (up_wreq || s_axi_wready || s_axi_bvalid) stable = 1'b0;
        step();
      end
      chk("w_lead_idle", 32'(stable), 32'd1);
      s_axi_awvalid = 1'b1;
      chk("aw_ready", 32'(s_axi_awready), 32'd1);
      step();
      s_axi_awvalid = 1'b0;
    end else begin
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      chk("aw_ready", 32'(s_axi_awready), 32'd1);
      chk("w_ready", 32'(s_axi_wready), 32'd1);
      step();
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
    end
    t = 0;
    nreq = 0;
    while (!s_axi_bvalid && t < 100) begin
      if (up_wreq) begin
        nreq++;
        if (t != 0) stable = 1'b0;
      end
      if (up_waddr !== addr[15:2] || up_wdata !== data) stable = 1'b0;
      up_wack = (t == d);
      step();
      up_wack = 1'b0;
      t++;
    end
    if (up_wreq) nreq++;
    chk("b_seen", 32'(s_axi_bvalid), 32'd1);
    chk("b_latency", 32'(t), 32'(lat));
    chk("wreq_pulses", 32'(nreq), ok ? 32'd1 : 32'd0);
    chk("w_stable", 32'(stable), 32'd1);
    chk("bresp", 32'(s_axi_bresp), resp_ok ? 32'd0 : 32'd2);
    br = s_axi_bresp;
    up_wack = 1'b1;
    up_rack = 1'b1;
    step();
    up_wack = 1'b0;
    up_rack = 1'b0;
    chk("b_late_ack", 32'({s_axi_bvalid, s_axi_bresp, up_wreq, up_rreq}), 32'({1'b1, br, 2'b00}));
    steady = 1'b1;
    repeat (hold) begin
      if (!s_axi_bvalid || s_axi_bresp !== br) steady = 1'b0;
      step();
    end
    chk("b_hold", 32'(steady), 32'd1);
    s_axi_bready = 1'b1;
    step();
    s_axi_bready = 1'b0;
    chk("b_done", 32'(s_axi_bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [15:0] addr, input int d, input logic [31:0] rd, input int hold);
    int t, nreq, lat;
    bit resp_ok, stable, steady;
    logic [31:0] rq;
    resp_ok = (d <= TO);
    lat     = ((d <= TO) ? d : TO) + 1;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    chk("ar_ready", 32'(s_axi_arready), 32'd1);
    step();
    s_axi_arvalid = 1'b0;
    t = 0;
    nreq = 0;
    stable = 1'b1;
    while (!s_axi_rvalid && t < 100) begin
      if (up_rreq) begin
        nreq++;
        if (t != 0) stable = 1'b0;
      end
      if (up_raddr !== addr[15:2]) stable = 1'b0;
      up_rack  = (t == d);
      up_rdata = (t == d) ? rd : $urandom();
      step();
      up_rack = 1'b0;
      t++;
    end
    chk("r_seen", 32'(s_axi_rvalid), 32'd1);
    chk("r_latency", 32'(t), 32'(lat));
    chk("rreq_pulses", 32'(nreq), 32'd1);
    chk("r_stable", 32'(stable), 32'd1);
    chk("rresp", 32'(s_axi_rresp), resp_ok ? 32'd0 : 32'd2);
    chk("rdata", s_axi_rdata, resp_ok ? rd : 32'hDEAD_DEAD);
    rq = s_axi_rdata;
    up_rack  = 1'b1;
    up_wack  = 1'b1;
    up_rdata = ~rq;
    step();
    up_rack = 1'b0;
    up_wack = 1'b0;
    chk("r_late_ack", 32'({s_axi_rvalid, up_rreq, up_wreq}), 32'b100);
    chk("r_late_data", s_axi_rdata, rq);
    steady = 1'b1;
    repeat (hold) begin
      if (!s_axi_rvalid || s_axi_rdata !== rq) steady = 1'b0;
      step();
    end
    chk("r_hold", 32'(steady), 32'd1);
    s_axi_rready = 1'b1;
    step();
    s_axi_rready = 1'b0;
    chk("r_done", 32'(s_axi_rvalid), 32'd0);
  endtask

  // AW, W and AR all offered together; records the order requests reach the UP bus.
  task automatic contested(input logic [15:0] exp_order);
    logic [15:0] order;
    int nresp, t;
    bit wq, rq;
    s_axi_awaddr = 16'h0100;
    s_axi_araddr = 16'h0200;
    s_axi_wdata  = 32'hA5A5_0001;
    s_axi_wstrb  = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_arvalid = 1'b1;
    step();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    order = '0;
    nresp = 0;
    t = 0;
    wq = 1'b0;
    rq = 1'b0;
    while (nresp < 2 && t < 200) begin
      up_wack = wq;
      up_rack = rq;
      wq = up_wreq;
      rq = up_rreq;
      if (up_wreq) order = {order[7:0], 8'h57};
      if (up_rreq) order = {order[7:0], 8'h52};
      if (s_axi_bvalid) nresp++;
      if (s_axi_rvalid) nresp++;
      step();
      t++;
    end
    up_wack = 1'b0;
    up_rack = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    chk("arb_responses", 32'(nresp), 32'd2);
    chk("arb_order", 32'(order), 32'(exp_order));
  endtask

  initial begin
    logic [15:0] a;
    logic [31:0] dt;
    logic [3:0]  sb;
    int dd, nb;

    up_rst = 1'b1;
    s_axi_awprot = 3'b000;
    s_axi_arprot = 3'b000;
    s_axi_awaddr = 16'h0004;
    s_axi_araddr = 16'h0004;
    s_axi_wdata  = 32'h1;
    s_axi_wstrb  = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    up_wack = 1'b0;
    up_rack = 1'b0;
    up_rdata = '0;
    repeat (3) step();
    chk("rst_ready", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
    chk("rst_outs", 32'(any_out), 32'd0);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    up_rst = 1'b0;
    step();
    chk("idle_ready", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'b111);
    chk("idle_outs", 32'({s_axi_bvalid, s_axi_rvalid, up_wreq, up_rreq}), 32'd0);

    contested("RW");
    contested("WR");

    axi_write(16'h0008, 32'h1234_5678, 4'hF, 1, 0, 0);
    chk("wr_addr", 32'(up_waddr), 32'd2);
    axi_read(16'h00A8, 1, 32'h0000_0001, 0);
    chk("rd_addr", 32'(up_raddr), 32'd42);

    axi_write(16'h0040, 32'hCAFE_F00D, 4'hF, 50, 0, 0);
    axi_read(16'h0044, 50, 32'h0BAD_BEEF, 0);
    axi_write(16'h0048, 32'h0000_00FF, 4'hF, TO, 0, 0);
    axi_read(16'h004C, TO + 1, 32'h0000_1111, 0);

    axi_write(16'h0050, 32'h5555_AAAA, 4'h3, 1, 0, 0);
    axi_write(16'h0054, 32'h8765_4321, 4'hF, 2, 5, 10);

    for (int k = 0; k < 10; k++) begin
      a  = 16'($urandom);
      dt = $urandom();
      dd = int'($urandom_range(1, 40));
      sb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 1) == 1) axi_write(a, dt, sb, dd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else axi_read(a, dd, dt, int'($urandom_range(0, 3)));
    end

    s_axi_awaddr = 16'h0010;
    s_axi_wdata  = 32'h0F0F_0F0F;
    s_axi_wstrb  = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    step();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    chk("mr_wreq", 32'(up_wreq), 32'd1);
    repeat (3) step();
    up_rst = 1'b1;
    #1;
    chk("mr_ready", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
    step();
    chk("mr_outs", 32'(any_out), 32'd0);
    up_rst = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    up_wack = 1'b1;
    nb = 0;
    repeat (40) begin
      if (s_axi_bvalid || s_axi_rvalid || up_wreq || up_rreq) nb++;
      step();
      up_wack = 1'b0;
    end
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    chk("mr_abandon", 32'(nb), 32'd0);
    axi_write(16'h0014, 32'h1357_9BDF, 4'hF, 3, 0, 2);

    chk("exclusive", 32'(excl_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
